// File: rtl/run_stream_gen.sv
// Serial run-length stream source: (bit, length) commands in over valid/ready, one bit per clk out.
// Define RUN_STREAM_GEN_MODEL_Z_EN to add z_exp, a four-equal-bits detector model watching w.
module run_stream_gen #(
    parameter int unsigned LEN_W      = 4,
    parameter logic        IDLE_LEVEL = 1'b0
`ifdef RUN_STREAM_GEN_MODEL_Z_EN
    ,
    parameter int unsigned RUN_TH     = 4
`endif
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             cmd_valid,
    input  logic             cmd_bit,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_ready,
    input  logic             abort,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done
`ifdef RUN_STREAM_GEN_MODEL_Z_EN
    ,
    output logic             z_exp
`endif
);

    typedef enum logic {StIdle = 1'b0, StSend = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             b_q, b_d;
    logic             w_q, w_d;
    logic             w_valid_q, w_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             last_cycle, accept, load;

    // Reload is only possible at cnt==1, so the counter can never wrap.
    assign last_cycle = (state_q == StSend) && (cnt_q == LEN_W'(1));
    assign cmd_ready  = !abort && ((state_q == StIdle) || last_cycle);
    assign accept     = cmd_valid && cmd_ready;
    assign load       = accept && (cmd_len != '0);

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            b_q       <= 1'b0;
            w_q       <= IDLE_LEVEL;
            w_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            b_q       <= b_d;
            w_q       <= w_d;
            w_valid_q <= w_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        case (state_q)
            StIdle: begin
                if (load) begin
                    state_d = StSend;
                    cnt_d   = cmd_len;
                    b_d     = cmd_bit;
                end
            end
            StSend: begin
                if (abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (load) begin
                    cnt_d = cmd_len;
                    b_d   = cmd_bit;
                end else if (last_cycle) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        w_d       = (state_d == StSend) ? b_d : IDLE_LEVEL;
        w_valid_d = (state_d == StSend);
        busy_d    = (state_d == StSend);
        // A null command or a finishing run pulses done; abort suppresses it.
        done_d    = !abort && (((state_q == StIdle) && accept && (cmd_len == '0)) || last_cycle);
    end

    assign w       = w_q;
    assign w_valid = w_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef RUN_STREAM_GEN_MODEL_Z_EN
    localparam int unsigned RcW = $clog2(RUN_TH + 1);

    logic           last_q;
    logic [RcW-1:0] runc_q, runc_d;
    logic           z_q;

    // runc==0 marks "no sample yet since reset".
    always_comb begin
        if (runc_q == '0) begin
            runc_d = RcW'(1);
        end else if (w_q == last_q) begin
            runc_d = (runc_q >= RcW'(RUN_TH)) ? runc_q : runc_q + RcW'(1);
        end else begin
            runc_d = RcW'(1);
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            last_q <= 1'b0;
            runc_q <= '0;
            z_q    <= 1'b0;
        end else begin
            last_q <= w_q;
            runc_q <= runc_d;
            z_q    <= (runc_d >= RcW'(RUN_TH));
        end
    end

    assign z_exp = z_q;
`endif

endmodule
